seq_pattern_gen: RTL and testbench

- Serial bit-pattern transmitter. It drives a programmable bit pattern, MSB first, onto a single-bit stream that feeds the team's serial sequence detectors.
- It supports a repeat count and an idle gap between repetitions.
- Outputs are registered (Moore) so the downstream Mealy detector sees a clean, glitch-free input.
- It sits between test/control logic (start handshake) and any serial-bit consumer.

---
 rtl/seq_pkg.sv | 25 ++
 rtl/seq_pattern_gen_if.sv | 36 +++
 rtl/seq_down_counter.sv | 38 +++
 rtl/seq_pattern_gen.sv | 197 +++++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// ============================================================================
// Module  : seq_pkg
// Brief   : Shared types and constants for the serial pattern generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic       IDLE_BIT_DEF = 1'b0;

    // Canonical stimulus pattern shared with the sequence-detector benches
    localparam logic [3:0] PAT_0110     = 4'b0110;
    localparam int         PAT_0110_LEN = 4;

endpackage

`default_nettype wire

// File: rtl/seq_pattern_gen_if.sv
// ============================================================================
// Module  : seq_pattern_gen_if
// Brief   : Control/stream bundle between a pattern requester and the generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_pattern_gen_if #(
    parameter int PAT_W = 4,
    parameter int LEN_W = $clog2(PAT_W + 1),
    parameter int CNT_W = 4
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] reps;
    logic [CNT_W-1:0] gap;
    logic             abort;
    logic             o;
    logic             o_vld;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, pattern, len, reps, gap, abort,
        input  o, o_vld, busy, done, err
    );

    modport slave (
        input  start, pattern, len, reps, gap, abort,
        output o, o_vld, busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/seq_down_counter.sv
// ============================================================================
// Module  : seq_down_counter
// Brief   : Loadable down counter that saturates at zero, with a zero flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_down_counter #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    input  wire logic             i_dec,
    output logic      [WIDTH-1:0] o_count,
    output logic                  o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load wins over decrement; decrement never wraps below zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/seq_pattern_gen.sv
// ============================================================================
// Module  : seq_pattern_gen
// Brief   : Serial MSB-first pattern transmitter with repeat count and idle gap.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int   PAT_W    = 4,
    parameter int   LEN_W    = $clog2(PAT_W + 1),
    parameter int   CNT_W    = 4,
    parameter logic IDLE_BIT = IDLE_BIT_DEF
) (
    input  wire logic         c,
    input  wire logic         r,
    seq_pattern_gen_if.slave  bus
);

    localparam logic [LEN_W-1:0] c_LEN_MAX = LEN_W'(PAT_W);

    state_t           r_state;
    logic             r_o;
    logic             r_o_vld;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic [CNT_W-1:0] r_gap;

    logic             w_legal;
    logic             w_accept;
    logic             w_reject;
    logic             w_kill;
    logic [CNT_W-1:0] w_rep_eff;
    logic             w_last_bit;
    logic             w_rep_last;
    logic             w_gap_last;
    logic             w_bit_load;
    logic [LEN_W-1:0] w_bit_load_val;
    logic             w_bit_dec;
    logic [LEN_W-1:0] w_next_idx;
    logic [PAT_W-1:0] w_src;
    logic             w_next_o;
    logic             w_rep_load;
    logic             w_rep_dec;
    logic             w_gap_load;
    logic             w_gap_dec;
    logic [LEN_W-1:0] w_bit_count;
    logic             w_bit_zero;
    logic [CNT_W-1:0] w_rep_count;
    logic             w_rep_zero;
    logic [CNT_W-1:0] w_gap_count;
    logic             w_gap_zero;

    always_comb begin
        w_legal    = (bus.len != '0) && (bus.len <= c_LEN_MAX);
        w_accept   = (r_state == IDLE) && bus.start && w_legal;
        w_reject   = (r_state == IDLE) && bus.start && !w_legal;
        w_kill     = (r_state != IDLE) && bus.abort;
        w_rep_eff  = (bus.reps == '0) ? CNT_W'(1) : bus.reps;

        w_last_bit = w_bit_zero;
        w_rep_last = (w_rep_count == CNT_W'(1)) || w_rep_zero;
        w_gap_last = (w_gap_count == CNT_W'(1)) || w_gap_zero;

        // A repetition boundary either reloads the bit index directly or via GAP
        w_bit_load = w_accept
                   || ((r_state == SHIFT) && !w_kill && w_last_bit && !w_rep_last && (r_gap == '0))
                   || ((r_state == GAP) && !w_kill && w_gap_last);
        w_bit_load_val = (r_state == IDLE) ? (bus.len - LEN_W'(1)) : (r_len - LEN_W'(1));
        w_bit_dec  = (r_state == SHIFT) && !w_kill && !w_last_bit;

        w_next_idx = w_bit_load ? w_bit_load_val : (w_bit_count - LEN_W'(1));
        w_src      = (r_state == IDLE) ? bus.pattern : r_pat;
        w_next_o   = |(w_src & (PAT_W'(1) << w_next_idx));

        w_rep_load = w_accept;
        w_rep_dec  = (r_state == SHIFT) && !w_kill && w_last_bit && !w_rep_last;
        w_gap_load = w_rep_dec && (r_gap != '0);
        w_gap_dec  = (r_state == GAP) && !w_kill && !w_gap_last;
    end

    seq_down_counter #(.WIDTH(LEN_W)) u_bit_cnt (
        .clk        (c),
        .rst        (r),
        .i_load     (w_bit_load),
        .i_load_val (w_bit_load_val),
        .i_dec      (w_bit_dec),
        .o_count    (w_bit_count),
        .o_zero     (w_bit_zero)
    );

    seq_down_counter #(.WIDTH(CNT_W)) u_rep_cnt (
        .clk        (c),
        .rst        (r),
        .i_load     (w_rep_load),
        .i_load_val (w_rep_eff),
        .i_dec      (w_rep_dec),
        .o_count    (w_rep_count),
        .o_zero     (w_rep_zero)
    );

    seq_down_counter #(.WIDTH(CNT_W)) u_gap_cnt (
        .clk        (c),
        .rst        (r),
        .i_load     (w_gap_load),
        .i_load_val (r_gap),
        .i_dec      (w_gap_dec),
        .o_count    (w_gap_count),
        .o_zero     (w_gap_zero)
    );

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            r_state <= IDLE;
            r_o     <= IDLE_BIT;
            r_o_vld <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_pat   <= '0;
            r_len   <= '0;
            r_gap   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            // Abort outranks everything, including a same-cycle completion
            if (w_kill) begin
                r_state <= IDLE;
                r_o     <= IDLE_BIT;
                r_o_vld <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_pat   <= bus.pattern;
                            r_len   <= bus.len;
                            r_gap   <= bus.gap;
                            r_state <= SHIFT;
                            r_o     <= w_next_o;
                            r_o_vld <= 1'b1;
                            r_busy  <= 1'b1;
                        end else if (w_reject) begin
                            r_err <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (!w_last_bit) begin
                            r_o <= w_next_o;
                        end else if (w_rep_last) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                            r_o     <= IDLE_BIT;
                            r_o_vld <= 1'b0;
                        end else if (r_gap == '0) begin
                            r_o <= w_next_o;
                        end else begin
                            r_state <= GAP;
                            r_o     <= IDLE_BIT;
                            r_o_vld <= 1'b0;
                        end
                    end
                    GAP: begin
                        if (w_gap_last) begin
                            r_state <= SHIFT;
                            r_o     <= w_next_o;
                            r_o_vld <= 1'b1;
                        end
                    end
                    FIN: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_o     <= IDLE_BIT;
                        r_o_vld <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o     = r_o;
    assign bus.o_vld = r_o_vld;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
// ============================================================================
// Module  : tb_seq_pattern_gen
// Brief   : Directed self-checking bench for seq_pattern_gen.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_pattern_gen;
    import seq_pkg::*;

    localparam int PAT_W = 4;
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int CNT_W = 4;

    logic c = 1'b0;
    logic r = 1'b1;

    seq_pattern_gen_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    seq_pattern_gen #(
        .PAT_W    (PAT_W),
        .LEN_W    (LEN_W),
        .CNT_W    (CNT_W),
        .IDLE_BIT (1'b0)
    ) dut (
        .c   (c),
        .r   (r),
        .bus (bus)
    );

    always #5 c = ~c;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge c);
        #1;
    endtask

    // Observed vector is {o, o_vld, busy, done, err}
    task automatic expect_out(input string tag, input logic [4:0] exp);
        check_val(tag, {27'b0, bus.o, bus.o_vld, bus.busy, bus.done, bus.err}, {27'b0, exp});
    endtask

    // seq holds n 5-bit expected vectors, first cycle in the most significant field
    task automatic expect_seq(input string tag, input int n, input logic [79:0] seq);
        for (int i = 0; i < n; i++) begin
            step();
            bus.start = 1'b0;
            expect_out($sformatf("%s c%0d", tag, i + 1), seq[(n - 1 - i) * 5 +: 5]);
        end
    endtask

    task automatic start_xfer(input logic [3:0] pat, input logic [2:0] l,
                              input logic [3:0] rp, input logic [3:0] g);
        bus.pattern = pat;
        bus.len     = l;
        bus.reps    = rp;
        bus.gap     = g;
        bus.start   = 1'b1;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.pattern = '0;
        bus.len     = '0;
        bus.reps    = '0;
        bus.gap     = '0;
        bus.abort   = 1'b0;

        #3;
        expect_out("reset held", 5'b00000);
        step();
        r = 1'b0;
        step();
        expect_out("reset released", 5'b00000);

        start_xfer(PAT_0110, 3'(PAT_0110_LEN), 4'd1, 4'd0);
        expect_seq("basic", 6, 80'({5'b01100, 5'b11100, 5'b11100, 5'b01100, 5'b00110, 5'b00000}));

        start_xfer(PAT_0110, 3'd4, 4'd2, 4'd0);
        expect_seq("b2b", 2, 80'({5'b01100, 5'b11100}));
        start_xfer(4'b1111, 3'd4, 4'd5, 4'd3);
        expect_seq("b2b_ign", 8, 80'({5'b11100, 5'b01100, 5'b01100, 5'b11100,
                                      5'b11100, 5'b01100, 5'b00110, 5'b00000}));

        start_xfer(4'b0101, 3'd3, 4'd2, 4'd2);
        expect_seq("gap", 10, 80'({5'b11100, 5'b01100, 5'b11100, 5'b00100, 5'b00100,
                                   5'b11100, 5'b01100, 5'b11100, 5'b00110, 5'b00000}));

        start_xfer(PAT_0110, 3'd0, 4'd1, 4'd0);
        expect_seq("rej_len0", 2, 80'({5'b00001, 5'b00000}));
        start_xfer(PAT_0110, 3'd5, 4'd1, 4'd0);
        expect_seq("rej_len5", 2, 80'({5'b00001, 5'b00000}));

        start_xfer(PAT_0110, 3'd4, 4'd1, 4'd0);
        expect_seq("abort", 1, 80'(5'b01100));
        step();
        expect_out("abort c2", 5'b11100);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        expect_out("abort idle", 5'b00000);
        start_xfer(PAT_0110, 3'd4, 4'd1, 4'd0);
        expect_seq("restart", 6, 80'({5'b01100, 5'b11100, 5'b11100, 5'b01100, 5'b00110, 5'b00000}));

        start_xfer(PAT_0110, 3'd4, 4'd1, 4'd0);
        expect_seq("abort_last", 4, 80'({5'b01100, 5'b11100, 5'b11100, 5'b01100}));
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        expect_out("abort_last idle", 5'b00000);

        bus.abort = 1'b1;
        start_xfer(PAT_0110, 3'd4, 4'd1, 4'd0);
        step();
        bus.start = 1'b0;
        expect_out("abort_start", 5'b01100);
        step();
        bus.abort = 1'b0;
        expect_out("abort_start kill", 5'b00000);

        start_xfer(4'b0001, 3'd1, 4'd1, 4'd0);
        expect_seq("fin", 1, 80'(5'b11100));
        start_xfer(PAT_0110, 3'd4, 4'd1, 4'd0);
        step();
        expect_out("fin start ignored", 5'b00110);
        step();
        expect_out("fin idle", 5'b00000);
        step();
        bus.start = 1'b0;
        expect_out("fin restart c1", 5'b01100);
        expect_seq("fin_restart", 5, 80'({5'b11100, 5'b11100, 5'b01100, 5'b00110, 5'b00000}));

        start_xfer(4'b0001, 3'd1, 4'd0, 4'd0);
        expect_seq("reps0", 3, 80'({5'b11100, 5'b00110, 5'b00000}));

        start_xfer(PAT_0110, 3'd4, 4'd1, 4'd0);
        expect_seq("rst", 2, 80'({5'b01100, 5'b11100}));
        #2;
        r = 1'b1;
        #1;
        expect_out("rst async", 5'b00000);
        r = 1'b0;
        step();
        expect_out("rst after", 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
